uart_tx_frame: RTL
==================

# uart_tx_frame

Parametrised UART transmit framer: next generation of the team's UART transmitter, generalised in data width, baud rate, parity mode and stop-bit count. Accepts one word per handshake and serialises it LSB first as start bit, data, optional parity and stop bit(s), holding each bit for a programmable number of clocks. Sits between the host-side register/FIFO logic and the TX pad; the UART receiver and its scoreboard consume its output.

## Interface
- DATA_WIDTH, 8: data bits per frame, legal 5..9.
- CLKS_PER_BIT, 16: clocks per serial bit, legal 2..65535.
- PARITY_MODE, 0: 0 none, 1 even, 2 odd. Legal only with UART_TX_PARITY_EN defined.
- STOP_BITS, 1: 1 or 2.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- tx_enable  in  1  block enable; low aborts any frame and holds idle.
- tx_start  in  1  request to send tx_data_in.
- tx_data_in  in  DATA_WIDTH  word to send.
- tx_out  out  1  serial line, idle high.
- busy  out  1  frame in progress; start is ignored while high.
- valid  out  1  one-cycle pulse: frame completed.

## Operation
- Reset values: tx_out=1, busy=0, valid=0, FSM=IDLE, bit and baud counters 0, shift register 0.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: tx_out=1. Accept when tx_enable=1, tx_start=1, busy=0. On accept, latch tx_data_in and compute parity from the latched value, then go to START.
- START: tx_out=0 for CLKS_PER_BIT clocks, then DATA.
- DATA: send bit 0 first. Each bit is held CLKS_PER_BIT clocks. After DATA_WIDTH bits, go to PARITY if parity is enabled, otherwise to STOP.
- PARITY: even mode sends ^data. Odd mode sends ~^data. The bit is held CLKS_PER_BIT clocks.
- STOP: tx_out=1 for STOP_BITS×CLKS_PER_BIT clocks, then IDLE with valid pulsed.
- tx_out is registered, with no combinational path from any input.
- Baud counter counts CLKS_PER_BIT-1 down to 0 and reloads on every bit boundary. Its width is $clog2(CLKS_PER_BIT).
- Bit counter width is $clog2(DATA_WIDTH+1). It never wraps within a frame.
- tx_data_in changing after accept has no effect on the frame in flight.
- tx_enable low in any state: on the next edge FSM=IDLE, tx_out=1, busy=0. No valid pulse. Counters are cleared.
- rst mid-frame: outputs go to reset values immediately (asynchronous). The partial frame is dropped.
- tx_start while busy=1 is ignored. No queuing.

## Timing
- Accept edge = cycle 0. Cycle 1: busy=1, tx_out=0 (start bit).
- Frame length: N = 1 + DATA_WIDTH + P + STOP_BITS bits, where P=1 if parity is enabled, else 0. Total N×CLKS_PER_BIT clocks of line time.
- busy is high from cycle 1 through cycle N×CLKS_PER_BIT inclusive.
- valid=1 and busy=0 in cycle N×CLKS_PER_BIT+1, for exactly one cycle.
- Back-to-back: tx_start high in the valid cycle is accepted. The next start bit begins in the following cycle, so there is at least one idle-high clock between frames.

## Configuration
- UART_TX_PARITY_EN defined: PARITY state and parity logic are compiled in, and PARITY_MODE 0/1/2 is honoured.
- Not defined: no PARITY state or parity logic, DATA goes directly to STOP, P=0. A nonzero PARITY_MODE is an elaboration error.

## Structure
- Shared package uart_pkg holds:
  - FSM state enum: uart_tx_state_t.
  - Parity-mode constants: UART_PARITY_NONE/EVEN/ODD.
  - Frame-length helper function.
  - The UART receiver uses the same package.
- Sub-module uart_baud_gen: loadable down-counter with a bit-boundary tick output, parametrised by CLKS_PER_BIT. The receiver reuses it.

## Test plan
- Reset mid-frame: assert rst during DATA -> tx_out=1, busy=0, valid=0 immediately. No valid pulse follows.
- DATA_WIDTH=8, CLKS_PER_BIT=4, even parity, send 0xA5:
  - Line (4 clocks each) = 0, 1,0,1,0,0,1,0,1, 0, 1.
  - busy high for 44 clocks; valid in cycle 45.
- Odd parity, send 0x00 -> parity bit 1. No parity, STOP_BITS=2, send 0xFF -> 0, eight 1s, then 1,1; 11×CLKS_PER_BIT clocks.
- tx_start held high continuously with two different words:
  - Second word accepted in the valid cycle.
  - Exactly one idle-high clock between the frames.
  - tx_start pulses while busy are ignored.
- tx_enable dropped during PARITY -> next edge tx_out=1, busy=0, no valid. Re-enable and send 0x3C -> complete correct frame.
- DATA_WIDTH=5, CLKS_PER_BIT=2, send 0x1F with UART_TX_PARITY_EN undefined -> 0,1,1,1,1,1,1; 14 busy clocks.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: TX/RX FSM state encoding, parity-mode codes and frame helpers.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_tx_state_t;

  localparam int UART_PARITY_NONE = 0;
  localparam int UART_PARITY_EVEN = 1;
  localparam int UART_PARITY_ODD  = 2;

  // Line bits in one frame: start + data + optional parity + stop bit(s).
  function automatic int uart_frame_bits(input int data_width, input int parity_mode,
                                         input int stop_bits);
    return 1 + data_width + ((parity_mode != UART_PARITY_NONE) ? 1 : 0) + stop_bits;
  endfunction

  // Parity bit for a data word that is zero-extended to 9 bits.
  function automatic logic uart_parity(input logic [8:0] data, input int parity_mode);
    case (parity_mode)
      UART_PARITY_EVEN: return ^data;
      UART_PARITY_ODD:  return ~^data;
      default:          return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Loadable baud down-counter: runs CLKS_PER_BIT-1..0 and reloads itself at each bit boundary.
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic load,
  output logic tick
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] RELOAD = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_r;

  // Counter register: clear has priority, load starts a fresh bit, zero wraps to a new bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= '0;
    end else if (clear) begin
      cnt_r <= '0;
    end else if (load) begin
      cnt_r <= RELOAD;
    end else if (cnt_r == '0) begin
      cnt_r <= RELOAD;
    end else begin
      cnt_r <= cnt_r - CW'(1);
    end
  end

  assign tick = (cnt_r == '0);

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmit framer: start, DATA_WIDTH bits LSB first, optional parity, 1-2 stop bits.
// Parity support is compiled in only when UART_TX_PARITY_EN is defined.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_MODE  = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tx_enable,
  input  logic                  tx_start,
  input  logic [DATA_WIDTH-1:0] tx_data_in,
  output logic                  tx_out,
  output logic                  busy,
  output logic                  valid
);

  localparam int BCW = $clog2(DATA_WIDTH + 1);

  if (DATA_WIDTH < 5 || DATA_WIDTH > 9) begin : g_bad_width
    $error("uart_tx_frame: DATA_WIDTH must be 5..9");
  end
  if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535) begin : g_bad_cpb
    $error("uart_tx_frame: CLKS_PER_BIT must be 2..65535");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_tx_frame: STOP_BITS must be 1 or 2");
  end
`ifdef UART_TX_PARITY_EN
  if (PARITY_MODE < UART_PARITY_NONE || PARITY_MODE > UART_PARITY_ODD) begin : g_bad_parity
    $error("uart_tx_frame: PARITY_MODE must be 0, 1 or 2");
  end
`else
  if (PARITY_MODE != UART_PARITY_NONE) begin : g_bad_parity
    $error("uart_tx_frame: PARITY_MODE needs UART_TX_PARITY_EN");
  end
`endif

  uart_tx_state_t        state_r, state_s;
  logic [DATA_WIDTH-1:0] data_r, data_s;
  logic [BCW-1:0]        bit_cnt_r, bit_cnt_s;
  logic                  tx_out_r, tx_s;
  logic                  busy_r, busy_s;
  logic                  valid_r, valid_s;
  logic                  load_s, clear_s, tick_s;
`ifdef UART_TX_PARITY_EN
  logic                  parity_r, parity_s;
`endif

  uart_baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk   (clk),
    .rst   (rst),
    .clear (clear_s),
    .load  (load_s),
    .tick  (tick_s)
  );

  // Frame state and line registers; every output is driven straight from a flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      data_r    <= '0;
      bit_cnt_r <= '0;
      tx_out_r  <= 1'b1;
      busy_r    <= 1'b0;
      valid_r   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_r  <= 1'b0;
`endif
    end else begin
      state_r   <= state_s;
      data_r    <= data_s;
      bit_cnt_r <= bit_cnt_s;
      tx_out_r  <= tx_s;
      busy_r    <= busy_s;
      valid_r   <= valid_s;
`ifdef UART_TX_PARITY_EN
      parity_r  <= parity_s;
`endif
    end
  end

  // Next-state logic; tx_s is the level the line takes for the coming bit.
  always_comb begin
    state_s   = state_r;
    data_s    = data_r;
    bit_cnt_s = bit_cnt_r;
    tx_s      = tx_out_r;
    busy_s    = busy_r;
    valid_s   = 1'b0;
    load_s    = 1'b0;
    clear_s   = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_s  = parity_r;
`endif
    if (!tx_enable) begin
      state_s   = IDLE;
      tx_s      = 1'b1;
      busy_s    = 1'b0;
      bit_cnt_s = '0;
      clear_s   = 1'b1;
    end else begin
      case (state_r)
        IDLE: begin
          tx_s   = 1'b1;
          busy_s = 1'b0;
          if (tx_start && !busy_r) begin
            data_s    = tx_data_in;
`ifdef UART_TX_PARITY_EN
            parity_s  = uart_parity(9'(tx_data_in), PARITY_MODE);
`endif
            load_s    = 1'b1;
            state_s   = START;
            tx_s      = 1'b0;
            busy_s    = 1'b1;
            bit_cnt_s = '0;
          end else begin
            clear_s = 1'b1;
          end
        end
        START: begin
          if (tick_s) begin
            state_s   = DATA;
            tx_s      = data_r[0];
            data_s    = {1'b0, data_r[DATA_WIDTH-1:1]};
            bit_cnt_s = BCW'(1);
          end else begin
            tx_s = 1'b0;
          end
        end
        DATA: begin
          if (tick_s && (bit_cnt_r == BCW'(DATA_WIDTH))) begin
`ifdef UART_TX_PARITY_EN
            if (PARITY_MODE != UART_PARITY_NONE) begin
              state_s = PARITY;
              tx_s    = parity_r;
            end else begin
              state_s   = STOP;
              tx_s      = 1'b1;
              bit_cnt_s = BCW'(1);
            end
`else
            state_s   = STOP;
            tx_s      = 1'b1;
            bit_cnt_s = BCW'(1);
`endif
          end else if (tick_s) begin
            tx_s      = data_r[0];
            data_s    = {1'b0, data_r[DATA_WIDTH-1:1]};
            bit_cnt_s = bit_cnt_r + BCW'(1);
          end else begin
            tx_s = tx_out_r;
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (tick_s) begin
            state_s   = STOP;
            tx_s      = 1'b1;
            bit_cnt_s = BCW'(1);
          end else begin
            tx_s = parity_r;
          end
        end
`endif
        STOP: begin
          tx_s = 1'b1;
          if (tick_s && (bit_cnt_r == BCW'(STOP_BITS))) begin
            state_s   = IDLE;
            busy_s    = 1'b0;
            valid_s   = 1'b1;
            bit_cnt_s = '0;
            clear_s   = 1'b1;
          end else if (tick_s) begin
            bit_cnt_s = bit_cnt_r + BCW'(1);
          end else begin
            bit_cnt_s = bit_cnt_r;
          end
        end
        default: begin
          state_s   = IDLE;
          tx_s      = 1'b1;
          busy_s    = 1'b0;
          bit_cnt_s = '0;
          clear_s   = 1'b1;
        end
      endcase
    end
  end

  assign tx_out = tx_out_r;
  assign busy   = busy_r;
  assign valid  = valid_r;

endmodule
